trig_delta_pulse_gen: RTL and testbench
=======================================

// Module: trig_delta_pulse_gen
// PURPOSE
//  Transmit side of the LV1A delta-pattern trigger: generates ET and veto word streams in the
//  exact isolated-delta form the delta trigger type recognises (zero / pulse / zero).
//  Sits in the top CDT test path, muxed ahead of the ET and veto inputs of the trigger logic,
//  for calibration and trigger-efficiency runs. Emits a burst of N pulses at a fixed period.
// PARAMETERS
//  PERIOD_W  16  width of the pulse-period register, in clocks
//  NPULSE_W  16  width of the pulse-count register and the sent-pulse counter
// PORTS
//  clk          in   1         system clock
//  rst          in   1         synchronous reset, active-high
//  in_live      in   1         run live; low aborts the burst and holds the block idle
//  user_ena     in   1         register enable; sampled only when start is accepted
//  start        in   1         burst request, single-cycle pulse
//  stop         in   1         burst abort, single-cycle pulse
//  pulse_et     in   16        ET magnitude placed in the pulse word
//  pulse_veto   in   32        veto bit pattern placed in the pulse word
//  period       in   PERIOD_W  clocks between consecutive pulse cycles (values < 3 act as 3)
//  npulse       in   NPULSE_W  pulses per burst; 0 = continuous until stop or in_live low
//  out_et       out  17        ET stream: bit16 = hit flag, [15:0] = magnitude
//  out_veto     out  32        veto stream
//  out_strobe   out  1         high exactly on pulse cycles
//  busy         out  1         burst in progress
//  done         out  1         one-cycle pulse on normal burst completion
//  npulse_sent  out  NPULSE_W  pulses emitted in the current or last burst, saturating
// BEHAVIOUR
//  - All outputs are registered. On rst, and in every cycle in_live is low, all outputs are 0
//    and the state is IDLE. Asserting rst or dropping in_live mid-burst gives zero outputs
//    from the next cycle and no done.
//  - FSM states: IDLE, PRE, PULSE, GAP, POST.
//  - IDLE: out_et and out_veto are 0. Start is accepted when start & in_live & user_ena.
//    Accepting start latches pulse_et, pulse_veto, max(period,3) and npulse,
//    clears npulse_sent, and moves to PRE. Start is ignored outside IDLE.
//  - Timing, with the start accepted at edge 0:
//    - Edge 1: PRE, outputs 0, busy=1.
//    - Edge 2: PULSE, out_et = {1'b1, pulse_et}, out_veto = pulse_veto, out_strobe = 1,
//      npulse_sent + 1.
//    - GAP: outputs 0 for P-1 cycles, then the next PULSE at edge 2+P, 2+2P, ...
//  - Every pulse word is therefore preceded and followed by all-zero ET (all 17 bits) and
//    all-zero veto words. The hit flag is set even when pulse_et = 0.
//  - After pulse number npulse (npulse != 0) the FSM goes to POST (outputs 0) instead of GAP.
//    In the following cycle it is in IDLE with done=1 for 1 cycle and busy=0.
//  - npulse = 0: the burst never completes on its own; npulse_sent saturates at all-ones.
//  - stop in any non-IDLE state: IDLE next cycle, outputs 0, busy=0, no done.
//    stop in the same cycle as an accepted start: stop wins and start is dropped.
//    stop in IDLE has no effect.
//  - npulse = 1: exactly one pulse, i.e. PRE, PULSE, POST, then done.
//  - The period counter loads P-1 at each PULSE and counts down in GAP; the next PULSE is
//    taken at count 0. No wrap is possible because P ≤ 2^PERIOD_W - 1.
//  - Latched values are stable for the whole burst; input changes mid-burst have no effect.
// STRUCTURE
//  - Shared package trig_cdt_pkg: ET_W = 17, ET_HIT_BIT = 16, VETO_W = 32, MIN_DELTA_PERIOD = 3,
//    and the state enum type delta_gen_state_t.
//  - Single module, no sub-modules. The period down-counter and the saturating pulse counter
//    are inline.
// TESTING
//  1. Single pulse: npulse=1, period=10, pulse_et=0x0123, pulse_veto=0x0000_0005, start at edge 0
//     -> out_et = 0x10123 and out_veto = 5 at edge 2 only; zeros at edges 1 and 3;
//     done=1 at edge 4; npulse_sent = 1.
//  2. Burst: npulse=4, period=5 -> strobes at edges 2, 7, 12, 17; done at edge 19;
//     outputs zero on all non-strobe cycles.
//  3. Period clamp: period=0 and period=1 -> pulses every 3 clocks; each pulse word is flanked
//     by zero words.
//  4. Continuous and abort: npulse=0, period=4, stop at edge 9 -> pulses at edges 2, 6; IDLE at
//     edge 10 with no done, npulse_sent = 2. Repeat with in_live dropped at edge 7 -> outputs 0
//     from edge 8, busy=0.
//  5. Gating: start with user_ena=0, or start while busy -> no effect. Change pulse_et
//     mid-burst -> later pulses still carry the latched value.
//  6. Loopback into the delta trigger type (et threshold 0x0100, veto pattern 0x5):
//     pulse_et = 0x0123 -> one LV1A with et_raw = 0x0123; pulse_et = 0x0050 -> no LV1A.

Source files
------------

// File: rtl/trig_cdt_pkg.sv
// Shared constants and types for the CDT trigger test path.
// Word widths match the ET and veto inputs of the trigger logic.
package trig_cdt_pkg;

    localparam int unsigned ET_W             = 17;
    localparam int unsigned ET_HIT_BIT       = 16;
    localparam int unsigned VETO_W           = 32;
    localparam int unsigned MIN_DELTA_PERIOD = 3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PRE,
        ST_PULSE,
        ST_GAP,
        ST_POST
    } delta_gen_state_t;

endpackage

// File: rtl/trig_delta_pulse_gen.sv
// Delta-pattern trigger stimulus: bursts of isolated ET/veto pulse words,
// each flanked by all-zero words, at a fixed period.
module trig_delta_pulse_gen
    import trig_cdt_pkg::*;
#(
    parameter int unsigned PERIOD_W = 16,
    parameter int unsigned NPULSE_W = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_live,
    input  logic                user_ena,
    input  logic                start,
    input  logic                stop,
    input  logic [15:0]         pulse_et,
    input  logic [31:0]         pulse_veto,
    input  logic [PERIOD_W-1:0] period,
    input  logic [NPULSE_W-1:0] npulse,
    output logic [ET_W-1:0]     out_et,
    output logic [VETO_W-1:0]   out_veto,
    output logic                out_strobe,
    output logic                busy,
    output logic                done,
    output logic [NPULSE_W-1:0] npulse_sent
);

    localparam logic [PERIOD_W-1:0] MIN_PERIOD = PERIOD_W'(MIN_DELTA_PERIOD);
    localparam logic [PERIOD_W-1:0] ONE_P      = PERIOD_W'(1);
    localparam logic [NPULSE_W-1:0] ONE_N      = NPULSE_W'(1);

    delta_gen_state_t    state_q, state_d;
    logic [15:0]         et_q, et_d;
    logic [VETO_W-1:0]   veto_q, veto_d;
    logic [PERIOD_W-1:0] per_q, per_d;
    logic [PERIOD_W-1:0] cnt_q, cnt_d;
    logic [NPULSE_W-1:0] npl_q, npl_d;
    logic [NPULSE_W-1:0] sent_q, sent_d, sent_inc;
    logic                fin_q, fin_d;
    logic [ET_W-1:0]     out_et_q, out_et_d;
    logic [VETO_W-1:0]   out_veto_q, out_veto_d;
    logic                out_strobe_q, out_strobe_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;

    always_comb begin
        state_d      = state_q;
        et_d         = et_q;
        veto_d       = veto_q;
        per_d        = per_q;
        cnt_d        = cnt_q;
        npl_d        = npl_q;
        sent_d       = sent_q;
        fin_d        = 1'b0;
        out_et_d     = '0;
        out_veto_d   = '0;
        out_strobe_d = 1'b0;
        busy_d       = 1'b0;
        done_d       = 1'b0;
        sent_inc     = (&sent_q) ? sent_q : sent_q + ONE_N;

        if (!in_live) begin
            state_d = ST_IDLE;
            sent_d  = '0;
        end else if (stop && state_q != ST_IDLE) begin
            state_d = ST_IDLE;
        end else begin
            // Output words are a registered image of the current state, so the
            // visible stream trails the state register by one clock.
            busy_d = (state_q != ST_IDLE);
            done_d = fin_q;
            case (state_q)
                ST_IDLE: begin
                    if (start && user_ena && !stop) begin
                        et_d    = pulse_et;
                        veto_d  = pulse_veto;
                        per_d   = (period < MIN_PERIOD) ? MIN_PERIOD : period;
                        npl_d   = npulse;
                        sent_d  = '0;
                        state_d = ST_PRE;
                    end
                end
                ST_PRE: state_d = ST_PULSE;
                ST_PULSE: begin
                    out_et_d[ET_HIT_BIT]     = 1'b1;
                    out_et_d[ET_HIT_BIT-1:0] = et_q;
                    out_veto_d               = veto_q;
                    out_strobe_d             = 1'b1;
                    sent_d                   = sent_inc;
                    cnt_d                    = per_q - ONE_P;
                    if (npl_q != '0 && sent_inc == npl_q) state_d = ST_POST;
                    else                                   state_d = ST_GAP;
                end
                ST_GAP: begin
                    cnt_d = cnt_q - ONE_P;
                    if (cnt_q == ONE_P) state_d = ST_PULSE;
                end
                ST_POST: begin
                    state_d = ST_IDLE;
                    fin_d   = 1'b1;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            et_q         <= '0;
            veto_q       <= '0;
            per_q        <= '0;
            cnt_q        <= '0;
            npl_q        <= '0;
            sent_q       <= '0;
            fin_q        <= 1'b0;
            out_et_q     <= '0;
            out_veto_q   <= '0;
            out_strobe_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            et_q         <= et_d;
            veto_q       <= veto_d;
            per_q        <= per_d;
            cnt_q        <= cnt_d;
            npl_q        <= npl_d;
            sent_q       <= sent_d;
            fin_q        <= fin_d;
            out_et_q     <= out_et_d;
            out_veto_q   <= out_veto_d;
            out_strobe_q <= out_strobe_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    assign out_et      = out_et_q;
    assign out_veto    = out_veto_q;
    assign out_strobe  = out_strobe_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign npulse_sent = sent_q;

endmodule

// File: tb/tb_trig_delta_pulse_gen.sv
// Bench for trig_delta_pulse_gen: each burst is predicted edge by edge from
// the pulse-timing arithmetic (2 + k*P) and compared against the outputs.
module tb_trig_delta_pulse_gen;

    localparam int PW  = 16;
    localparam int NW  = 16;
    localparam int BIG = 1 << 30;

    logic          clk = 1'b0;
    logic          rst, in_live, user_ena, start, stop;
    logic [15:0]   pulse_et;
    logic [31:0]   pulse_veto;
    logic [PW-1:0] period;
    logic [NW-1:0] npulse;
    logic [16:0]   out_et;
    logic [31:0]   out_veto;
    logic          out_strobe, busy, done;
    logic [NW-1:0] npulse_sent;

    int n_checks = 0;
    int n_pass   = 0;
    int last_sent = 0;

    trig_delta_pulse_gen #(.PERIOD_W(PW), .NPULSE_W(NW)) dut (
        .clk(clk), .rst(rst), .in_live(in_live), .user_ena(user_ena),
        .start(start), .stop(stop), .pulse_et(pulse_et), .pulse_veto(pulse_veto),
        .period(period), .npulse(npulse), .out_et(out_et), .out_veto(out_veto),
        .out_strobe(out_strobe), .busy(busy), .done(done), .npulse_sent(npulse_sent)
    );

    always #5 clk = ~clk;

    // One burst started at edge 0; edges 1..ncyc are predicted and checked.
    task automatic run_burst(input string name, input logic [15:0] et, input logic [31:0] veto,
                             input int per, input int np, input int stop_e, input int live_e,
                             input int ncyc, input bit jitter);
        int P, last, sent_m;
        bit inf, killed, pulse, e_busy, e_done;
        logic [16:0] e_et;
        logic [31:0] e_veto;
        P      = (per < 3) ? 3 : per;
        inf    = (np == 0);
        last   = inf ? BIG : 2 + (np - 1) * P;
        sent_m = 0;
        pulse_et = et; pulse_veto = veto; period = PW'(per); npulse = NW'(np);
        user_ena = 1'b1; in_live = 1'b1; stop = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int e = 1; e <= ncyc; e++) begin
            stop    = (e == stop_e);
            in_live = (e < live_e);
            if (jitter) begin
                pulse_et   = 16'($urandom);
                pulse_veto = $urandom;
                period     = PW'($urandom_range(0, 20));
                npulse     = NW'($urandom_range(0, 9));
                user_ena   = 1'($urandom);
                start      = ((e <= last + 1 && e <= stop_e) || e >= live_e)
                             && ($urandom_range(0, 2) == 0);
            end
            @(posedge clk); #1;
            killed = (e >= stop_e) || (e >= live_e);
            pulse  = !killed && e >= 2 && ((e - 2) % P == 0) && (inf || (e - 2) / P < np);
            if (pulse) sent_m++;
            if (e >= live_e) sent_m = 0;
            e_busy = !killed && (e <= last + 1);
            e_done = !killed && !inf && (e == last + 2);
            e_et   = pulse ? {1'b1, et} : 17'h0;
            e_veto = pulse ? veto : 32'h0;
            n_checks++;
            if ({out_et, out_veto, out_strobe, busy, done, npulse_sent} !==
                {e_et, e_veto, pulse, e_busy, e_done, NW'(sent_m)})
                $display("FAIL %s edge=%0d got et=%h veto=%h stb=%b busy=%b done=%b sent=%0d want et=%h veto=%h stb=%b busy=%b done=%b sent=%0d",
                         name, e, out_et, out_veto, out_strobe, busy, done, npulse_sent,
                         e_et, e_veto, pulse, e_busy, e_done, sent_m);
            else n_pass++;
        end
        last_sent = sent_m;
        start = 1'b0; stop = 1'b0; in_live = 1'b1; user_ena = 1'b1;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic check_quiet(input string name, input int exp_sent);
        n_checks++;
        if ({out_et, out_veto, out_strobe, busy, done, npulse_sent} !== {17'h0, 32'h0, 3'b000, NW'(exp_sent)})
            $display("FAIL %s got et=%h veto=%h stb=%b busy=%b done=%b sent=%0d want all zero sent=%0d",
                     name, out_et, out_veto, out_strobe, busy, done, npulse_sent, exp_sent);
        else n_pass++;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_live = 1'b1; user_ena = 1'b1; start = 1'b1; stop = 1'b0;
        pulse_et = 16'hFFFF; pulse_veto = '1; period = 16'd4; npulse = 16'd2;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check_quiet("reset", 0);
        end
        start = 1'b0; rst = 1'b0;
        @(posedge clk); #1;
        check_quiet("after_reset", 0);
    endtask

    task automatic test_reset_midburst();
        pulse_et = 16'h0AAA; pulse_veto = 32'h55; period = 16'd4; npulse = 16'd3;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (out_strobe !== 1'b0 || busy !== 1'b1 || npulse_sent !== 16'd1)
            $display("FAIL pre_rst got stb=%b busy=%b sent=%0d want stb=0 busy=1 sent=1",
                     out_strobe, busy, npulse_sent);
        else n_pass++;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check_quiet("rst_mid", 0);
        repeat (6) begin
            @(posedge clk); #1;
            check_quiet("rst_mid_idle", 0);
        end
        last_sent = 0;
    endtask

    task automatic test_single_pulse();
        run_burst("single", 16'h0123, 32'h0000_0005, 10, 1, BIG, BIG, 8, 1'b0);
    endtask

    task automatic test_burst();
        run_burst("burst4", 16'($urandom), $urandom, 5, 4, BIG, BIG, 22, 1'b0);
        run_burst("burst_et0", 16'h0000, 32'h0, 7, 2, BIG, BIG, 14, 1'b0);
    endtask

    task automatic test_period_clamp();
        for (int p = 0; p <= 3; p++)
            run_burst("clamp", 16'($urandom), $urandom, p, 4, BIG, BIG, 16, 1'b0);
    endtask

    task automatic test_abort();
        run_burst("stop", 16'h0042, 32'h0000_00F0, 4, 0, 9, BIG, 13, 1'b0);
        run_burst("live", 16'h0042, 32'h0000_00F0, 4, 0, BIG, 8, 12, 1'b0);
        run_burst("stop_post", 16'h0777, 32'h1, 3, 2, 6, BIG, 9, 1'b0);
    endtask

    task automatic test_gating();
        int held;
        run_burst("pre_gate", 16'h0321, 32'h3, 3, 2, BIG, BIG, 8, 1'b0);
        held = last_sent;
        pulse_et = 16'h1111; period = 16'd3; npulse = 16'd2;
        user_ena = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; user_ena = 1'b1;
        repeat (4) begin
            @(posedge clk); #1;
            check_quiet("ena_low", held);
        end
        start = 1'b1; stop = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; stop = 1'b0;
        repeat (4) begin
            @(posedge clk); #1;
            check_quiet("start_stop", held);
        end
        stop = 1'b1;
        @(posedge clk); #1;
        stop = 1'b0;
        check_quiet("stop_idle", held);
    endtask

    task automatic test_mid_burst_changes();
        run_burst("jitter", 16'h0123, 32'h5, 6, 5, BIG, BIG, 32, 1'b1);
        run_burst("jitter_cont", 16'h0BEE, 32'hCAFE_F00D, 3, 0, 20, BIG, 24, 1'b1);
    endtask

    task automatic test_random();
        for (int k = 0; k < 10; k++) begin
            int per, np, last, s, l, mode;
            per  = $urandom_range(0, 9);
            np   = $urandom_range(1, 5);
            last = 2 + (np - 1) * ((per < 3) ? 3 : per);
            mode = $urandom_range(0, 2);
            s = BIG; l = BIG;
            if (mode == 1) s = $urandom_range(1, last + 1);
            if (mode == 2) l = $urandom_range(1, last + 3);
            run_burst("random", 16'($urandom), $urandom, per, np, s, l, last + 4, 1'($urandom));
        end
    endtask

    initial begin
        test_reset();
        test_reset_midburst();
        test_single_pulse();
        test_burst();
        test_period_clamp();
        test_abort();
        test_gating();
        test_mid_burst_changes();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
